vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_sync_gen_if.sv | 22 ++
 rtl/sync_delay_line.sv | 39 +++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for 640x480@60 and the types shared by the VGA sync generator.
// The module parameter defaults and the interface widths both come from here.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int POS_W = 10;
  localparam int CNT_W = 8;

  typedef logic [POS_W-1:0] pos_t;

  // Bit order matches the {display_on, vsync, hsync} delay-line vector.
  typedef struct packed {
    logic display_on;
    logic vsync;
    logic hsync;
  } sync_bits_t;

  function automatic logic in_window(pos_t pos, pos_t lo, pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing outputs of the VGA sync generator, bundled for the display pipeline.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  pos_t             hpos;
  pos_t             vpos;
  logic             line_start;
  logic             frame_start;
  logic [CNT_W-1:0] frame_cnt;
  logic             hsync;
  logic             vsync;
  logic             display_on;

  modport master (
    output hpos, vpos, line_start, frame_start, frame_cnt, hsync, vsync, display_on
  );

  modport slave (
    input hpos, vpos, line_start, frame_start, frame_cnt, hsync, vsync, display_on
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous reset to RESET_VAL.
// DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, reset};
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stage;

      always_ff @(posedge clk) begin
        // NOTE: the stages are reset rather than left X so that q holds the idle vector until the pipe refills.
        if (reset) begin
          stage <= {DEPTH{RESET_VAL}};
        end else begin
          // NOTE: <= makes every stage take its neighbour's pre-edge value, so loop order is irrelevant.
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, frame counter, and sync/blank
// decodes delayed by PIPE_DELAY clocks to line up with a downstream pixel pipe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = H_DISPLAY_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_DISPLAY  = V_DISPLAY_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
  localparam pos_t H_VIS  = pos_t'(H_DISPLAY);
  localparam pos_t V_VIS  = pos_t'(V_DISPLAY);
  localparam pos_t HS_LO  = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_HI  = pos_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam pos_t VS_LO  = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_HI  = pos_t'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam sync_bits_t IDLE = '{display_on: 1'b0, vsync: ~VSYNC_POL, hsync: ~HSYNC_POL};

  pos_t             hpos_q, hpos_d;
  pos_t             vpos_q, vpos_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             line_start_q, frame_start_q;
  sync_bits_t       lvl, dly;

  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
    hpos_d      = hpos_q + 1'b1;
    vpos_d      = vpos_q;
    frame_cnt_d = frame_cnt_q;
    if (hpos_q == H_LAST) begin
      hpos_d = '0;
      if (vpos_q == V_LAST) begin
        vpos_d      = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        vpos_d = vpos_q + 1'b1;
      end
    end
  end

  // Start pulses are registered from the next-state counters so they align with hpos/vpos.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_cnt_q   <= '0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_cnt_q   <= frame_cnt_d;
      line_start_q  <= (hpos_d == '0);
      frame_start_q <= (hpos_d == '0) && (vpos_d == '0);
    end
  end

  // Polarity is folded in before the delay so the reset vector is simply the idle level.
  always_comb begin
    lvl            = IDLE;
    lvl.hsync      = in_window(hpos_q, HS_LO, HS_HI) ? HSYNC_POL : ~HSYNC_POL;
    lvl.vsync      = in_window(vpos_q, VS_LO, VS_HI) ? VSYNC_POL : ~VSYNC_POL;
    lvl.display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
  end

  sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (IDLE)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     (lvl),
    .q     (dly)
  );

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.frame_cnt   = frame_cnt_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = dly.hsync;
  assign vga.vsync       = dly.vsync;
  assign vga.display_on  = dly.display_on;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations checked every clock against an
// arithmetic model (position = cycles since reset), plus directed timing checks.
module tb_vga_sync_gen;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
    int dly;
    bit hpol; bit vpol;
  } geom_t;

  localparam geom_t G_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
  localparam geom_t G_B = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 1'b1, 1'b1};
  localparam geom_t G_C = '{8, 2, 3, 2, 4, 1, 2, 1, 3, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();
  vga_sync_gen_if if_c ();

  vga_sync_gen #(.PIPE_DELAY(2)) dut_a (.clk(clk), .reset(reset), .vga(if_a));

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(0)
  ) dut_b (.clk(clk), .reset(reset), .vga(if_b));

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DELAY(3)
  ) dut_c (.clk(clk), .reset(reset), .vga(if_c));

  logic [32:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.hpos, if_a.vpos, if_a.frame_cnt, if_a.line_start, if_a.frame_start,
                  if_a.hsync, if_a.vsync, if_a.display_on};
  assign obs_b = {if_b.hpos, if_b.vpos, if_b.frame_cnt, if_b.line_start, if_b.frame_start,
                  if_b.hsync, if_b.vsync, if_b.display_on};
  assign obs_c = {if_c.hpos, if_c.vpos, if_c.frame_cnt, if_c.line_start, if_c.frame_start,
                  if_c.hsync, if_c.vsync, if_c.display_on};

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Measurement state
  bit meas_en = 1'b0;
  logic prev_hs_a = 1'b1, prev_de_a = 1'b0, prev_vs_b = 1'b0, prev_vs_c = 1'b1;
  int hs_fall_h = -1, hs_rise_h = -1, hs_low = 0, de_fall_h = -1;
  int vs_run_b = 0, vs_len_b = -1;
  int c_vs_h = -1, c_vs_v = -1, vs_run_c = 0, vs_len_c = -1;
  bit fs_seen_b = 1'b0;
  int fs_gap_b = 0, fs_count = 0;

  // Expected outputs after tt non-reset clocks since the last reset edge.
  function automatic logic [32:0] model(int tt, geom_t g);
    int ht, vt, h, v, fc, td, dh, dv;
    logic hs_act, vs_act, de, hs, vs;
    ht = g.hd + g.hf + g.hs + g.hb;
    vt = g.vd + g.vf + g.vs + g.vb;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    fc = (tt / (ht * vt)) % 256;
    hs_act = 1'b0;
    vs_act = 1'b0;
    de     = 1'b0;
    if (tt >= g.dly) begin
      td = tt - g.dly;
      dh = td % ht;
      dv = (td / ht) % vt;
      hs_act = (dh >= g.hd + g.hf) && (dh < g.hd + g.hf + g.hs);
      vs_act = (dv >= g.vd + g.vf) && (dv < g.vd + g.vf + g.vs);
      de     = (dh < g.hd) && (dv < g.vd);
    end
    hs = hs_act ? g.hpol : !g.hpol;
    vs = vs_act ? g.vpol : !g.vpol;
    return {10'(h), 10'(v), 8'(fc), (h == 0), (h == 0) && (v == 0), hs, vs, de};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic cmp_vec(string tag, logic [32:0] obs, logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h (hpos,vpos,fcnt,ls,fs,hs,vs,de)", tag, t, obs, exp);
    end
  endtask

  task automatic monitor();
    if (if_a.vpos == 10'd1) begin
      if (prev_hs_a && !if_a.hsync && hs_fall_h < 0) hs_fall_h = int'(if_a.hpos);
      if (hs_fall_h >= 0 && hs_rise_h < 0) begin
        if (!if_a.hsync) hs_low++;
        else if (!prev_hs_a) hs_rise_h = int'(if_a.hpos);
      end
      if (prev_de_a && !if_a.display_on && de_fall_h < 0) de_fall_h = int'(if_a.hpos);
    end
    if (meas_en) begin
      if (if_b.vsync) vs_run_b++;
      else if (prev_vs_b && vs_len_b < 0) vs_len_b = vs_run_b;
      if (!if_c.vsync && c_vs_h < 0) begin
        c_vs_h = int'(if_c.hpos);
        c_vs_v = int'(if_c.vpos);
      end
      if (!if_c.vsync) vs_run_c++;
      else if (!prev_vs_c && vs_len_c < 0) vs_len_c = vs_run_c;
      if (if_b.frame_start) begin
        if (fs_seen_b) begin
          chk("frame_period_b", 32'(fs_gap_b), 32'd120);
          fs_count++;
        end
        fs_seen_b = 1'b1;
        fs_gap_b  = 1;
      end else begin
        fs_gap_b++;
      end
    end
    prev_hs_a = if_a.hsync;
    prev_de_a = if_a.display_on;
    prev_vs_b = if_b.vsync;
    prev_vs_c = if_c.vsync;
  endtask

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) t = 0;
    else t++;
    @(negedge clk);
    cmp_vec("model_a", obs_a, model(t, G_A));
    cmp_vec("model_b", obs_b, model(t, G_B));
    cmp_vec("model_c", obs_c, model(t, G_C));
    monitor();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n, m;

    // Reset held 5 clocks, then released
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    chk("rst_hpos",        32'(if_a.hpos), 32'd0);
    chk("rst_vpos",        32'(if_a.vpos), 32'd0);
    chk("rst_frame_cnt",   32'(if_a.frame_cnt), 32'd0);
    chk("rst_hsync",       32'(if_a.hsync), 32'd1);
    chk("rst_vsync",       32'(if_a.vsync), 32'd1);
    chk("rst_display_on",  32'(if_a.display_on), 32'd0);
    chk("rst_line_start",  32'(if_a.line_start), 32'd1);
    chk("rst_frame_start", 32'(if_a.frame_start), 32'd1);

    // Line wrap at hpos=799, vpos=10
    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      if (if_a.hpos == 10'd799 && if_a.vpos == 10'd10) found = 1'b1;
      else tick();
    end
    chk("line_wrap_reached", 32'(found), 32'd1);
    tick();
    chk("wrap_hpos",        32'(if_a.hpos), 32'd0);
    chk("wrap_vpos",        32'(if_a.vpos), 32'd11);
    chk("wrap_line_start",  32'(if_a.line_start), 32'd1);
    chk("wrap_frame_start", 32'(if_a.frame_start), 32'd0);

    // hsync / display_on timing measured on line 1
    chk("hsync_fall_hpos",   32'(hs_fall_h), 32'd658);
    chk("hsync_low_clocks",  32'(hs_low), 32'd96);
    chk("hsync_rise_hpos",   32'(hs_rise_h), 32'd754);
    chk("display_fall_hpos", 32'(de_fall_h), 32'd642);

    // Mid-frame reset for one clock at hpos=300
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (if_a.hpos == 10'd300) found = 1'b1;
      else tick();
    end
    chk("mid_reset_reached", 32'(found), 32'd1);
    chk("mid_pre_display_on", 32'(if_a.display_on), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_hpos",        32'(if_a.hpos), 32'd0);
    chk("mid_vpos",        32'(if_a.vpos), 32'd0);
    chk("mid_display_on0", 32'(if_a.display_on), 32'd0);
    chk("mid_hsync0",      32'(if_a.hsync), 32'd1);
    tick();
    chk("mid_display_on1", 32'(if_a.display_on), 32'd0);
    chk("mid_vsync1",      32'(if_a.vsync), 32'd1);
    tick();
    chk("mid_display_on2", 32'(if_a.display_on), 32'd1);
    chk("mid_hpos2",       32'(if_a.hpos), 32'd2);

    // Random run lengths and reset bursts, checked against the model every clock
    for (int k = 0; k < 40; k++) begin
      n = int'($urandom_range(0, 400));
      repeat (n) tick();
      reset = 1'b1;
      m = int'($urandom_range(1, 3));
      repeat (m) tick();
      reset = 1'b0;
    end

    // Long run on the small geometry: frame period, vsync width, frame counter wrap
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    meas_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 32000 && !found; i++) begin
      if (if_b.frame_cnt == 8'd255 && if_b.hpos == 10'd14 && if_b.vpos == 10'd7) found = 1'b1;
      else tick();
    end
    chk("frame_wrap_reached", 32'(found), 32'd1);
    tick();
    chk("fwrap_hpos",        32'(if_b.hpos), 32'd0);
    chk("fwrap_vpos",        32'(if_b.vpos), 32'd0);
    chk("fwrap_frame_cnt",   32'(if_b.frame_cnt), 32'd0);
    chk("fwrap_frame_start", 32'(if_b.frame_start), 32'd1);
    chk("frame_periods_seen", 32'(fs_count > 200), 32'd1);
    chk("vsync_len_b",        32'(vs_len_b), 32'd30);
    chk("vsync_start_hpos_c", 32'(c_vs_h), 32'd3);
    chk("vsync_start_vpos_c", 32'(c_vs_v), 32'd5);
    chk("vsync_len_c",        32'(vs_len_c), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
